switch_conditioner: RTL and testbench

SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

---
 rtl/switch_conditioner.sv | 61 ++++++
 tb/tb_switch_conditioner.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
// switch_conditioner: synchronizes and debounces board switches and exposes
// level, sticky edge and mask registers with an edge interrupt.
module switch_conditioner #(
  parameter int N_SW = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SW-1:0]   sw_raw,
  output logic [N_SW-1:0]   sw_level,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [N_SW-1:0]   r_sync1, r_sync2, r_level, w_diff, w_load;
  logic [CW-1:0]     r_cnt [N_SW];
  logic [2*N_SW-1:0] r_edge, r_mask, w_clr;
  logic [31:0]       r_rdata, w_rdata;
  logic              w_wr_edge, w_wr_mask, w_unused;
  always_comb begin
    w_diff = r_sync2 ^ r_level;
    w_load = '0;
    for (int k = 0; k < N_SW; k++) w_load[k] = w_diff[k] && (r_cnt[k] == C_LAST);
  end
  assign w_wr_edge = avs_write && (avs_address == 2'd1);
  assign w_wr_mask = avs_write && (avs_address == 2'd2);
  assign w_clr     = w_wr_edge ? avs_writedata[2*N_SW-1:0] : '0;
  assign w_unused  = ^avs_writedata;
  assign w_rdata = avs_address == 2'd0 ? 32'(r_level) :
                   avs_address == 2'd1 ? 32'(r_edge) :
                   avs_address == 2'd2 ? 32'(r_mask) : '0;
  // A new edge event ORs in after the W1C mask, so a same-cycle set survives
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      r_edge  <= '0;
      r_mask  <= '0;
      r_rdata <= '0;
      for (int k = 0; k < N_SW; k++) r_cnt[k] <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
      r_level <= r_level ^ w_load;
      r_edge  <= (r_edge & ~w_clr) | {w_load & ~r_sync2, w_load & r_sync2};
      if (w_wr_mask) r_mask <= avs_writedata[2*N_SW-1:0];
      if (avs_read && !avs_write) r_rdata <= w_rdata;
      for (int k = 0; k < N_SW; k++)
        r_cnt[k] <= (w_diff[k] && !w_load[k]) ? r_cnt[k] + CW'(1) : '0;
    end
  end
  assign sw_level     = r_level;
  assign avs_readdata = r_rdata;
  assign irq          = |(r_edge & r_mask);
endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed checks of debounce timing, edge/mask registers and reset.
module tb_switch_conditioner;
  logic        clk = 0;
  logic        reset = 1;
  logic [3:0]  sw_raw = '0;
  logic [3:0]  sw_level;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 0;
  logic        avs_write = 0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        irq;
  int n_checks = 0;
  int n_fail = 0;

  switch_conditioner #(.N_SW(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_level(sw_level),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1;
    step(1);
    avs_write = 0;
  endtask

  task automatic rd(input logic [1:0] a);
    avs_address = a; avs_read = 1;
    step(1);
    avs_read = 0;
  endtask

  initial begin
    step(3);
    check("reset_level", 32'(sw_level), 0);
    check("reset_rdata", avs_readdata, 0);
    check("reset_irq", 32'(irq), 0);
    reset = 0; sw_raw = 4'b0001;
    step(5);
    check("rise_early", 32'(sw_level), 0);
    step(1);
    check("rise_at_6", 32'(sw_level), 32'h1);
    rd(2'd1);
    check("edge_rise0", avs_readdata, 32'h01);
    check("irq_masked", 32'(irq), 0);
    sw_raw = 4'b0011;
    step(3);
    sw_raw = 4'b0001;
    step(8);
    check("glitch_level", 32'(sw_level), 32'h1);
    rd(2'd1);
    check("glitch_edge", avs_readdata, 32'h01);
    wr(2'd2, 32'h01);
    check("mask_irq_on", 32'(irq), 1);
    wr(2'd1, 32'h01);
    check("w1c_irq_off", 32'(irq), 0);
    rd(2'd1);
    check("w1c_edge", avs_readdata, 32'h00);
    rd(2'd2);
    check("mask_read", avs_readdata, 32'h01);
    sw_raw = 4'b0101;
    step(8);
    check("bit2_high", 32'(sw_level), 32'h5);
    wr(2'd1, 32'h04);
    rd(2'd1);
    check("bit2_rise_clr", avs_readdata, 32'h00);
    sw_raw = 4'b0001;
    step(5);
    avs_address = 2'd1; avs_writedata = 32'h40; avs_write = 1;
    step(1);
    avs_write = 0;
    check("fall_level", 32'(sw_level), 32'h1);
    rd(2'd1);
    check("fall_set_wins", avs_readdata, 32'h40);
    check("fall_irq_off", 32'(irq), 0);
    sw_raw = 4'b0011;
    step(5);
    avs_address = 2'd1; avs_read = 1;
    step(1);
    avs_read = 0;
    check("pre_update_read", avs_readdata, 32'h40);
    check("bit1_level", 32'(sw_level), 32'h3);
    rd(2'd1);
    check("post_update_read", avs_readdata, 32'h42);
    rd(2'd3);
    check("addr3_read", avs_readdata, 32'h0);
    rd(2'd0);
    check("level_read", avs_readdata, 32'h3);
    avs_address = 2'd2;
    step(2);
    check("rdata_hold", avs_readdata, 32'h3);
    wr(2'd0, 32'hFFFF_FFFF);
    check("level_wr_ignored", 32'(sw_level), 32'h3);
    avs_address = 2'd2; avs_writedata = 32'h0F; avs_read = 1; avs_write = 1;
    step(1);
    avs_read = 0; avs_write = 0;
    check("rw_read_ignored", avs_readdata, 32'h3);
    check("rw_irq", 32'(irq), 1);
    rd(2'd2);
    check("rw_mask_written", avs_readdata, 32'h0F);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd1);
    check("addr3_wr_ignored", avs_readdata, 32'h42);
    wr(2'd1, 32'hFF);
    check("clear_all_irq", 32'(irq), 0);
    sw_raw = 4'b1000;
    step(4);
    reset = 1;
    step(1);
    check("rst_level", 32'(sw_level), 0);
    check("rst_rdata", avs_readdata, 0);
    check("rst_irq", 32'(irq), 0);
    step(1);
    check("rst_level2", 32'(sw_level), 0);
    reset = 0;
    step(5);
    check("post_rst_early", 32'(sw_level), 0);
    step(1);
    check("post_rst_level", 32'(sw_level), 32'h8);
    rd(2'd1);
    check("post_rst_edge", avs_readdata, 32'h08);
    rd(2'd2);
    check("post_rst_mask", avs_readdata, 32'h00);
    check("post_rst_irq", 32'(irq), 0);
    wr(2'd2, 32'h08);
    check("mask_set_irq", 32'(irq), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
